// File: rtl/packet_source_arbiter.sv
// Packet-atomic round-robin arbiter: merges NUM_SOURCES framed beat streams into one
// registered output stream without interleaving packets, and reports framing errors.
module packet_source_arbiter #(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int BE_WIDTH    = DATA_WIDTH / 8,
  parameter int CNT_WIDTH   = 16,
  localparam int IDW        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SOURCES-1:0]            src_valid,
  output logic [NUM_SOURCES-1:0]            src_ready,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_payload,
  input  logic [NUM_SOURCES*BE_WIDTH-1:0]   src_byte_enable,
  input  logic [NUM_SOURCES-1:0]            src_sop,
  input  logic [NUM_SOURCES-1:0]            src_eop,
  output logic                              out_payload_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_payload,
  output logic [BE_WIDTH-1:0]               out_byte_enable,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic [IDW-1:0]                    out_src_id,
  output logic [CNT_WIDTH-1:0]              pkt_beats,
  output logic                              pkt_done,
  output logic                              err_no_sop,
  output logic                              err_missing_eop
);

  // state  | meaning
  // IDLE   | no source owns the output; grant the next sop requester round-robin
  // LOCKED | source gnt owns the output until it delivers an eop beat
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]              state;
  logic [IDW-1:0]          gnt;
  logic [IDW-1:0]          rr_ptr;
  logic [CNT_WIDTH-1:0]    cnt;

  logic [NUM_SOURCES-1:0]  cand;
  logic [NUM_SOURCES-1:0]  orphan;
  logic                    any_cand;
  logic                    any_orphan;
  logic                    found;
  logic [IDW-1:0]          sel;
  logic [IDW-1:0]          orphan_idx;
  logic [IDW-1:0]          src_idx;
  logic [IDW-1:0]          rr_next;
  logic                    can_load;
  logic                    take;
  logic                    drop;
  logic [DATA_WIDTH-1:0]   sel_payload;
  logic [BE_WIDTH-1:0]     sel_be;
  logic                    sel_sop;
  logic                    sel_eop;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  int                      idx;

  always_comb begin
    cand       = src_valid & src_sop;
    orphan     = src_valid & ~src_sop;
    any_cand   = |cand;
    any_orphan = |orphan;
    can_load   = !out_payload_valid || out_ready;

    sel   = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SOURCES;
      if (!found && cand[idx]) begin
        sel   = IDW'(idx);
        found = 1'b1;
      end
    end

    orphan_idx = '0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      if (orphan[k]) orphan_idx = IDW'(k);
    end

    rr_next = (int'(sel) == NUM_SOURCES - 1) ? '0 : sel + IDW'(1);
    src_idx = (state == ST_LOCKED) ? gnt : sel;

    sel_payload = src_payload[int'(src_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_be      = src_byte_enable[int'(src_idx)*BE_WIDTH +: BE_WIDTH];
    sel_sop     = src_sop[src_idx];
    sel_eop     = src_eop[src_idx];

    take = rst_n && can_load &&
           ((state == ST_LOCKED) ? src_valid[gnt] : any_cand);
    drop = rst_n && (state == ST_IDLE) && !any_cand && any_orphan;

    // Orphans are swallowed regardless of backpressure since they never reach the output.
    src_ready = '0;
    if (rst_n) begin
      if (state == ST_LOCKED)  src_ready[gnt]        = can_load;
      else if (any_cand)       src_ready[sel]        = can_load;
      else if (any_orphan)     src_ready[orphan_idx] = 1'b1;
    end

    cnt_inc = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      gnt               <= '0;
      rr_ptr            <= '0;
      cnt               <= '0;
      out_payload_valid <= 1'b0;
      out_payload       <= '0;
      out_byte_enable   <= '0;
      out_sop           <= 1'b0;
      out_eop           <= 1'b0;
      out_src_id        <= '0;
      pkt_beats         <= '0;
      pkt_done          <= 1'b0;
      err_no_sop        <= 1'b0;
      err_missing_eop   <= 1'b0;
    end else begin
      pkt_done        <= 1'b0;
      err_missing_eop <= 1'b0;
      err_no_sop      <= drop;

      if (take) begin
        out_payload_valid <= 1'b1;
        out_payload       <= sel_payload;
        out_byte_enable   <= sel_be;
        out_sop           <= sel_sop;
        out_eop           <= sel_eop;
        out_src_id        <= src_idx;

        if (sel_sop) begin
          cnt <= CNT_WIDTH'(1);
          if (state == ST_LOCKED) begin
            err_missing_eop <= 1'b1;
            if (!sel_eop) begin
              pkt_beats <= cnt;
              pkt_done  <= 1'b1;
            end
          end
        end else begin
          cnt <= cnt_inc;
        end

        // A completing beat's own count takes precedence over the truncated-packet report.
        if (sel_eop) begin
          pkt_beats <= sel_sop ? CNT_WIDTH'(1) : cnt_inc;
          pkt_done  <= 1'b1;
        end

        if (state == ST_IDLE) begin
          gnt    <= sel;
          rr_ptr <= rr_next;
          state  <= sel_eop ? ST_IDLE : ST_LOCKED;
        end else if (sel_eop) begin
          state <= ST_IDLE;
        end
      end else if (can_load) begin
        out_payload_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_packet_source_arbiter.sv
// Randomized bench for packet_source_arbiter against a transaction-rule reference model.
// A narrow beat counter is used so saturation is reachable with long packets.
module tb_packet_source_arbiter;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int BW  = 8;
  localparam int CW  = 3;
  localparam int IW  = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      src_valid;
  logic [N-1:0]      src_ready;
  logic [N*DW-1:0]   src_payload;
  logic [N*BW-1:0]   src_byte_enable;
  logic [N-1:0]      src_sop;
  logic [N-1:0]      src_eop;
  logic              out_payload_valid;
  logic              out_ready;
  logic [DW-1:0]     out_payload;
  logic [BW-1:0]     out_byte_enable;
  logic              out_sop;
  logic              out_eop;
  logic [IW-1:0]     out_src_id;
  logic [CW-1:0]     pkt_beats;
  logic              pkt_done;
  logic              err_no_sop;
  logic              err_missing_eop;

  packet_source_arbiter #(
    .NUM_SOURCES(N), .DATA_WIDTH(DW), .BE_WIDTH(BW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_payload(src_payload), .src_byte_enable(src_byte_enable),
    .src_sop(src_sop), .src_eop(src_eop),
    .out_payload_valid(out_payload_valid), .out_ready(out_ready),
    .out_payload(out_payload), .out_byte_enable(out_byte_enable),
    .out_sop(out_sop), .out_eop(out_eop), .out_src_id(out_src_id),
    .pkt_beats(pkt_beats), .pkt_done(pkt_done),
    .err_no_sop(err_no_sop), .err_missing_eop(err_missing_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: owner lock, pointer and counter as plain integers
  bit            m_locked;
  int            m_gnt, m_rr, m_cnt;
  bit            e_valid, e_sop, e_eop, e_done, e_nosop, e_miss;
  logic [DW-1:0] e_payload;
  logic [BW-1:0] e_be;
  int            e_id, e_beats;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_gnt = 0; m_rr = 0; m_cnt = 0;
    e_valid = 0; e_sop = 0; e_eop = 0; e_done = 0; e_nosop = 0; e_miss = 0;
    e_payload = '0; e_be = '0; e_id = 0; e_beats = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_payload_valid), 64'(e_valid));
    chk("out_payload", out_payload, e_payload);
    chk("out_be", 64'(out_byte_enable), 64'(e_be));
    chk("out_sop", 64'(out_sop), 64'(e_sop));
    chk("out_eop", 64'(out_eop), 64'(e_eop));
    chk("out_src_id", 64'(out_src_id), 64'(e_id));
    chk("pkt_beats", 64'(pkt_beats), 64'(e_beats));
    chk("pkt_done", 64'(pkt_done), 64'(e_done));
    chk("err_no_sop", 64'(err_no_sop), 64'(e_nosop));
    chk("err_missing_eop", 64'(err_missing_eop), 64'(e_miss));
  endtask

  task automatic drive_random(input int sop_pct, input int eop_pct, input int rdy_pct);
    for (int i = 0; i < N; i++) begin
      src_valid[i] = ($urandom_range(99) < 75);
      src_sop[i]   = ($urandom_range(99) < sop_pct);
      src_eop[i]   = ($urandom_range(99) < eop_pct);
      src_payload[i*DW +: DW]     = {$urandom, $urandom};
      src_byte_enable[i*BW +: BW] = BW'($urandom);
    end
    out_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic step(input int sop_pct, input int eop_pct, input int rdy_pct);
    bit           can, take, drop, bsop, beop;
    int           sel, orph, src, nxt;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    check_outputs();
    drive_random(sop_pct, eop_pct, rdy_pct);
    #1;
    can = !e_valid || out_ready;
    exp_ready = '0;
    sel = -1; orph = -1; src = -1;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && src_valid[(m_rr + k) % N] && src_sop[(m_rr + k) % N]) sel = (m_rr + k) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (orph < 0 && src_valid[i] && !src_sop[i]) orph = i;
      end
      if (sel >= 0) begin
        if (can) exp_ready[sel] = 1'b1;
      end else if (orph >= 0) begin
        exp_ready[orph] = 1'b1;
      end
      src = sel;
    end else begin
      src = m_gnt;
      exp_ready[m_gnt] = can;
    end
    chk("src_ready", 64'(src_ready), 64'(exp_ready));
    take = can && (src >= 0) && src_valid[src];
    drop = !m_locked && (sel < 0) && (orph >= 0);

    @(posedge clk);
    e_done = 0; e_miss = 0; e_nosop = drop;
    if (take) begin
      bsop = src_sop[src];
      beop = src_eop[src];
      e_valid = 1; e_sop = bsop; e_eop = beop; e_id = src;
      e_payload = src_payload[src*DW +: DW];
      e_be      = src_byte_enable[src*BW +: BW];
      if (bsop) begin
        if (m_locked) begin
          e_miss = 1;
          if (!beop) begin e_beats = m_cnt; e_done = 1; end
        end
        nxt = 1;
      end else begin
        nxt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
      end
      m_cnt = nxt;
      if (beop) begin e_beats = nxt; e_done = 1; end
      if (!m_locked) begin
        m_gnt = src;
        m_rr = (src + 1) % N;
        m_locked = !beop;
      end else if (beop) begin
        m_locked = 0;
      end
    end else if (can) begin
      e_valid = 0;
    end
  endtask

  task automatic mid_cycle_reset();
    @(negedge clk);
    drive_random(20, 10, 90);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    @(negedge clk);
    src_valid = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    src_valid = '0; src_sop = '0; src_eop = '0;
    src_payload = '0; src_byte_enable = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    chk("reset_src_ready", 64'(src_ready), 64'd0);
    rst_n = 1'b1;

    repeat (300) step(15, 20, 80);
    repeat (300) step(4, 4, 95);
    for (int r = 0; r < 10; r++) begin
      repeat (5) step(10, 10, 0);
      repeat (10) step(10, 10, 90);
    end
    repeat (200) step(15, 20, 30);
    for (int r = 0; r < 5; r++) begin
      repeat (8 + r) step(30, 10, 85);
      mid_cycle_reset();
    end
    repeat (400) step(25, 25, 75);
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
